// File: rtl/adc_pkg.sv
// Shared ADC code types, limits and output-register state encoding for the
// block averager.
package adc_pkg;

  localparam int unsigned ADC_CODE_W = 8;

  typedef logic signed [ADC_CODE_W-1:0] adc_code_t;

  localparam adc_code_t ADC_MAX_CODE = 8'sd127;
  localparam adc_code_t ADC_MIN_CODE = -8'sd127;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Half an LSB of the shifted result, so the shift rounds half toward +inf.
  function automatic int unsigned round_bias(input int unsigned log2n);
    return (log2n == 0) ? 0 : (32'd1 << (log2n - 1));
  endfunction

endpackage

// File: rtl/adc_minmax_tracker.sv
// Per-block running minimum/maximum of ADC codes. The _c outputs already
// include the sample presented this cycle, so they are valid on the last sample.
module adc_minmax_tracker
  import adc_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      update,
  input  logic      clear,
  input  adc_code_t code,
  output adc_code_t blk_min_c,
  output adc_code_t blk_max_c
);

  adc_code_t cur_min;
  adc_code_t cur_max;

  always_comb begin
    blk_min_c = cur_min;
    blk_max_c = cur_max;
    if (start) begin
      blk_min_c = code;
      blk_max_c = code;
    end else if (update) begin
      if (code < cur_min) blk_min_c = code;
      if (code > cur_max) blk_max_c = code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cur_min <= '0;
      cur_max <= '0;
    end else if (update) begin
      cur_min <= blk_min_c;
      cur_max <= blk_max_c;
    end
  end

endmodule

// File: rtl/adc_block_averager.sv
// Block averager for bipolar flash ADC codes: sums 2^LOG2_N samples and emits
// one rounded average per block through a single-entry valid/ready register.
// Define ADC_AVG_MINMAX_EN to add per-block min/max outputs.
module adc_block_averager
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_N    = 2,
  parameter int unsigned OVR_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [ADC_CODE_W-1:0] in_code,
  input  logic                        in_valid,
  output logic signed [ADC_CODE_W-1:0] out_avg,
  output logic                        out_valid,
  input  logic                        out_ready,
`ifdef ADC_AVG_MINMAX_EN
  output logic signed [ADC_CODE_W-1:0] out_min,
  output logic signed [ADC_CODE_W-1:0] out_max,
`endif
  output logic                        overrun,
  output logic [OVR_CNT_W-1:0]        ovr_cnt,
  input  logic                        clr_ovr
);

  localparam int unsigned ACC_W = ADC_CODE_W + LOG2_N;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
  // With LOG2_N=0 the counter sits at 0 and every accepted sample completes.
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'((32'd1 << LOG2_N) - 32'd1);
  localparam logic signed [SUM_W-1:0] BIAS     = SUM_W'(round_bias(LOG2_N));

  out_state_e              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  logic                    accept_c;
  logic                    done_c;
  logic                    load_c;
  logic                    drop_c;
  logic signed [ACC_W-1:0] acc_sum_c;
  logic signed [SUM_W-1:0] rounded_c;
  adc_code_t               avg_c;

  always_comb begin
    accept_c  = in_valid && en;
    done_c    = accept_c && (cnt == CNT_LAST);
    load_c    = done_c && ((state == OUT_EMPTY) || out_ready);
    drop_c    = done_c && (state == OUT_FULL) && !out_ready;
    acc_sum_c = acc + ACC_W'(in_code);
    rounded_c = SUM_W'(acc_sum_c) + BIAS;
    avg_c     = ADC_CODE_W'(rounded_c >>> LOG2_N);
  end

  // Accumulator and sample counter; restart on completion so blocks abut.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept_c) begin
      if (done_c) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum_c;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Output register FSM plus overrun bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OUT_EMPTY;
      out_valid <= 1'b0;
      out_avg   <= '0;
      overrun   <= 1'b0;
      ovr_cnt   <= '0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (done_c) begin
            state     <= OUT_FULL;
            out_valid <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (out_ready && !done_c) begin
            state     <= OUT_EMPTY;
            out_valid <= 1'b0;
          end
        end
      endcase

      if (load_c) out_avg <= avg_c;

      // A drop in the same cycle as clr_ovr wins and counts as the first.
      if (drop_c) begin
        overrun <= 1'b1;
        if (clr_ovr)
          ovr_cnt <= OVR_CNT_W'(1);
        else if (ovr_cnt != {OVR_CNT_W{1'b1}})
          ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
      end else if (clr_ovr) begin
        overrun <= 1'b0;
        ovr_cnt <= '0;
      end
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  adc_code_t blk_min_c;
  adc_code_t blk_max_c;

  adc_minmax_tracker u_minmax (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_c && (cnt == '0)),
    .update    (accept_c),
    .clear     (!en),
    .code      (in_code),
    .blk_min_c (blk_min_c),
    .blk_max_c (blk_max_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_min <= '0;
      out_max <= '0;
    end else if (load_c) begin
      out_min <= blk_min_c;
      out_max <= blk_max_c;
    end
  end
`endif

endmodule

// File: doc/adc_block_averager.md
# adc_block_averager

Downstream stage of the 8-bit bipolar flash converter. Takes its two's-complement output codes (nominal range -127..+127, 12.8 codes/V), accumulates blocks of 2^LOG2_N samples, and emits one rounded average per block through a single-entry valid/ready output register. Optional min/max tracking reports the per-block extremes. Results that are not drained in time are dropped, counted, and flagged.

## Interface
- LOG2_N, default 2: block length N = 2^LOG2_N; legal 0..8.
- OVR_CNT_W, default 8: width of the overrun counter.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  averaging enable; while 0, samples are ignored and the partial block is cleared.
- in_code  in  8  signed two's-complement ADC code.
- in_valid  in  1  in_code valid this cycle; no backpressure, and the sample is consumed when en=1.
- out_avg  out  8  signed block average.
- out_valid  out  1  out_avg (and min/max) hold a result.
- out_ready  in  1  consumer accepts the result when out_valid=1.
- out_min, out_max  out  8 each  signed block extremes (only with ADC_AVG_MINMAX_EN).
- overrun  out  1  sticky; set when a completed block is dropped.
- ovr_cnt  out  OVR_CNT_W  dropped-block count; saturates at all-ones.
- clr_ovr  in  1  clears overrun and ovr_cnt.

## Operation
- Accumulator acc: signed, 8+LOG2_N bits. Sample counter cnt: LOG2_N bits (no counter when LOG2_N=0).
- Accepted sample means in_valid=1 and en=1. It adds sign-extended in_code to acc and increments cnt.
- Block completion happens on the accepted sample with cnt = N-1. On that sample:
  - avg = (acc_final + 2^(LOG2_N-1)) >>> LOG2_N, using an arithmetic shift and rounding half toward +inf.
  - For LOG2_N=0, avg = in_code.
  - The result always fits in 8 bits and needs no clamp.
  - acc and cnt restart at 0 on the same edge, so there are no sample gaps between blocks.
- Output register FSM has two states:
  - EMPTY (out_valid=0) goes to FULL on block completion.
  - FULL goes to EMPTY on out_ready=1 when no block completes that cycle.
  - FULL with out_ready=1 and a completion in the same cycle stays FULL and loads the new result (drain and reload).
  - FULL with out_ready=0 and a completion: the new result is discarded, the held result is unchanged, overrun←1, and ovr_cnt increments (saturating).
- en=0 clears acc, cnt and the min/max trackers. The output register and overrun state are unaffected.
- clr_ovr=1 clears overrun and ovr_cnt. An overrun in the same cycle takes priority: overrun=1, ovr_cnt=1.
- -128 on in_code is accepted arithmetically even though the converter never produces it.

## Timing
- Reset values: out_avg=0, out_valid=0, out_min=0, out_max=0, overrun=0, ovr_cnt=0. Internally acc=0, cnt=0, and the FSM is EMPTY.
- Reset mid-block discards the partial block. The first accepted sample after rst deasserts starts a new block.
- Latency: out_valid rises on the clock edge that registers the Nth sample. The result is visible in the following cycle.
- Handshake: out_avg, out_min and out_max are stable while out_valid=1 and out_ready=0. Transfer occurs on any edge where both are 1.
- Sustained throughput: one result per N accepted samples with out_ready held at 1.

## Configuration
- ADC_AVG_MINMAX_EN defined:
  - Per-block running min and max are tracked, initialised from the block's first sample.
  - They are loaded into out_min and out_max together with out_avg, under the same drop rules.
- ADC_AVG_MINMAX_EN undefined:
  - The out_min and out_max ports are absent and no tracking logic is built.
  - Averaging behaviour is identical.

## Structure
- Shared package adc_pkg holds:
  - ADC_CODE_W=8, the adc_code_t signed typedef, and ADC_MAX_CODE=127 / ADC_MIN_CODE=-127.
  - The output FSM state enum (OUT_EMPTY, OUT_FULL).
- One sub-module, adc_minmax_tracker: per-block min/max with start/update/clear inputs. It is instantiated only under ADC_AVG_MINMAX_EN.

## Test plan
- LOG2_N=2, out_ready=1, samples 10,11,12,13 → out_avg=12 (46+2=48, >>>2) one cycle after the 4th sample; min=10, max=13.
- Samples -1,-1,-1,-2 → out_avg=-1 ((-5+2)>>>2). Samples -127×4 → -127. Samples 127×4 → 127, with no wrap.
- out_ready=0 across two completed blocks (avg 5 then 9) → out_avg stays 5, overrun=1, ovr_cnt=1. Then out_ready=1 → 5 transfers and out_valid drops.
- FULL with out_ready=1 on the same cycle as a completion → out_valid stays 1, new result loaded, no overrun.
- rst or en=0 after 3 samples of 100, then 4 samples of 4 → only one result, out_avg=4. clr_ovr with a simultaneous overrun → ovr_cnt=1.
